// File: rtl/layer_weight_loader.sv
// layer_weight_loader: streams weight words into a row memory with async read.
// Define LAYER_LOADER_CHECKSUM_EN to add a running checksum output.
module layer_weight_loader #(
  parameter int w_size      = 8,
  parameter int neurons_in  = 4,
  parameter int neurons_out = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [w_size-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          busy,
  output logic                          done,
  input  logic [neurons_in-1:0]         addr,
`ifdef LAYER_LOADER_CHECKSUM_EN
  output logic [neurons_out*w_size-1:0] data,
  output logic [w_size-1:0]             checksum
`else
  output logic [neurons_out*w_size-1:0] data
`endif
);

  localparam int row_w = neurons_out * w_size;
  localparam int depth = 1 << neurons_in;
  localparam int wcw   = (neurons_out > 1) ? $clog2(neurons_out) : 1;

  localparam logic [wcw-1:0]        last_k   = wcw'(neurons_out - 1);
  localparam logic [neurons_in-1:0] last_row = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state;
  logic [1:0]            nxt;
  logic [wcw-1:0]        word_cnt;
  logic [neurons_in-1:0] row_cnt;
  logic [row_w-1:0]      buf_q;
  logic [row_w-1:0]      row_full;
  logic [row_w-1:0]      mem [depth];

  logic is_idle;
  logic is_load;
  logic is_done;
  logic go;
  logic accept;
  logic last_word;
  logic final_word;

  assign is_idle    = (state == S_IDLE);
  assign is_load    = (state == S_LOAD);
  assign is_done    = (state == S_DONE);
  assign go         = start & (is_idle | is_done);
  assign accept     = is_load & in_valid;
  assign last_word  = (word_cnt == last_k);
  assign final_word = accept & last_word & (row_cnt == last_row);

  assign in_ready = is_load;
  assign busy     = is_load;
  assign done     = is_done;
  assign data     = mem[addr];

  // Next state; start is only honoured outside LOAD.
  always_comb begin
    nxt = state;
    unique case (1'b1)
      is_load: nxt = final_word ? S_DONE : S_LOAD;
      is_done: nxt = go ? S_LOAD : S_DONE;
      default: nxt = go ? S_LOAD : S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Word/row counters; row_cnt wraps to 0 on the final write.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      row_cnt  <= '0;
    end else if (go) begin
      word_cnt <= '0;
      row_cnt  <= '0;
    end else if (accept) begin
      if (last_word) begin
        word_cnt <= '0;
        row_cnt  <= row_cnt + 1'b1;
      end else begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // Row buffer holds all but the last word of the row being filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
    end else if (accept && !last_word) begin
      for (int k = 0; k < neurons_out - 1; k++) begin
        if (word_cnt == wcw'(k)) begin
          buf_q[k*w_size +: w_size] <= in_data;
        end
      end
    end
  end

  // Completed row: buffered words plus the word arriving now.
  always_comb begin
    row_full = buf_q;
    row_full[(neurons_out-1)*w_size +: w_size] = in_data;
  end

  // Row memory: cleared on reset, written once per completed row.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < depth; r++) begin
        mem[r] <= '0;
      end
    end else if (accept && last_word) begin
      mem[row_cnt] <= row_full;
    end
  end

`ifdef LAYER_LOADER_CHECKSUM_EN
  // Running modulo sum of words accepted since the last load began.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (go) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + in_data;
    end
  end
`endif

endmodule
